// File: rtl/mp_limb_seq_if.sv
// Limb-stream bundle for the multi-precision add/sub sequencer: start command,
// operand limb pairs in, result limbs out, plus status.
interface mp_limb_seq_if #(
    parameter int LIMB_W = 64
);
    logic              start_valid;
    logic              start_ready;
    logic              op_sub;
    logic              in_valid;
    logic              in_ready;
    logic [LIMB_W-1:0] in_a;
    logic [LIMB_W-1:0] in_b;
    logic              out_valid;
    logic              out_ready;
    logic [LIMB_W-1:0] out_sum;
    logic              out_last;
    logic              out_cy;
    logic              busy;
    logic              done;

    modport master (
        output start_valid, op_sub, in_valid, in_a, in_b, out_ready,
        input  start_ready, in_ready, out_valid, out_sum, out_last, out_cy, busy, done
    );

    modport slave (
        input  start_valid, op_sub, in_valid, in_a, in_b, out_ready,
        output start_ready, in_ready, out_valid, out_sum, out_last, out_cy, busy, done
    );
endinterface

// File: rtl/mp_limb_seq.sv
// Multi-precision add/sub sequencer: LS-first limb pairs through one adder, carry kept in a register.
// Latency: input limb handshake in cycle t -> registered result limb valid in cycle t+1.
// Backpressure: single output register; in_ready drops only while the output is held and out_ready is low.
module mp_limb_seq #(
    parameter int LIMB_W = 64,
    parameter int NLIMBS = 8
) (
    input  logic         clk,
    input  logic         rst,
    mp_limb_seq_if.slave bus
);
    localparam int CNT_W = (NLIMBS > 1) ? $clog2(NLIMBS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NLIMBS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              carry_q;
    logic              sub_r;
    logic              out_valid_q;
    logic [LIMB_W-1:0] out_sum_q;
    logic              out_last_q;
    logic              out_cy_q;
    logic              done_q;

    logic              start_rdy;
    logic              in_rdy;
    logic              start_hs;
    logic              in_hs;
    logic              out_hs;
    logic              last_beat;
    logic [LIMB_W:0]   add_res;

    assign last_beat = (cnt_q == LAST_IDX);
    assign start_hs  = start_rdy && bus.start_valid;
    assign in_hs     = in_rdy && bus.in_valid;
    assign out_hs    = out_valid_q && bus.out_ready;

    // Subtraction is a + ~b + 1, the +1 coming from the carry seeded at start.
    assign add_res = {1'b0, bus.in_a}
                   + {1'b0, bus.in_b ^ {LIMB_W{sub_r}}}
                   + {{LIMB_W{1'b0}}, carry_q};

    always_comb begin
        state_d   = state_q;
        start_rdy = 1'b0;
        in_rdy    = 1'b0;
        case (state_q)
            IDLE: begin
                start_rdy = 1'b1;
                if (bus.start_valid) state_d = RUN;
            end
            RUN: begin
                in_rdy = !out_valid_q || bus.out_ready;
                if (in_rdy && bus.in_valid && last_beat) state_d = DRAIN;
            end
            DRAIN: begin
                if (out_valid_q && bus.out_ready && out_last_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            sub_r       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_last_q  <= 1'b0;
            out_cy_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            if (start_hs) begin
                sub_r   <= bus.op_sub;
                carry_q <= bus.op_sub;
                cnt_q   <= '0;
            end
            if (in_hs) begin
                out_sum_q   <= add_res[LIMB_W-1:0];
                carry_q     <= add_res[LIMB_W];
                out_valid_q <= 1'b1;
                if (last_beat) begin
                    out_last_q <= 1'b1;
                    out_cy_q   <= add_res[LIMB_W];
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else if (out_hs) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
                out_cy_q    <= 1'b0;
                if (out_last_q) done_q <= 1'b1;
            end
        end
    end

    assign bus.start_ready = start_rdy;
    assign bus.in_ready    = in_rdy;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_sum     = out_sum_q;
    assign bus.out_last    = out_last_q;
    assign bus.out_cy      = out_cy_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
endmodule

// File: doc/mp_limb_seq.md
Name: mp_limb_seq

Overview:
Sequencer for multi-precision add/subtract in the crypto arithmetic datapath.
Accepts a start command, then streams operand limb pairs least-significant first through a single shared LIMB_W-bit adder stage.
Carries the inter-limb carry/borrow in a register and emits one registered result limb per accepted input limb.
Sits between the operand limb buffers and the compressor-tree / reduction stages downstream.

Parameters:
LIMB_W, 64, width of one limb in bits (>=2)
NLIMBS, 8, number of limbs per operation (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start_valid  in  1  start command valid
start_ready  out  1  start command accepted when high together with start_valid
op_sub  in  1  0 = a+b, 1 = a-b; sampled on the start handshake
in_valid  in  1  limb pair valid
in_ready  out  1  limb pair accepted when high together with in_valid
in_a  in  LIMB_W  operand A limb
in_b  in  LIMB_W  operand B limb
out_valid  out  1  result limb valid
out_ready  in  1  downstream accepts result limb
out_sum  out  LIMB_W  result limb
out_last  out  1  marks the final (most significant) limb
out_cy  out  1  final carry; valid only with out_last (sub: 1 = no borrow, a>=b)
busy  out  1  operation in progress (state != IDLE)
done  out  1  one-cycle pulse in the cycle after the last limb handshake

Behaviour:
- Clock is clk; reset is synchronous and active-high, on port rst. One clock domain.
- Reset values: state=IDLE, limb counter=0, carry=0, out_valid=0, out_sum=0, out_last=0, out_cy=0, done=0, busy=0.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - start_ready=1, in_ready=0.
  - On the start handshake: latch op_sub into sub_r, set carry=op_sub, clear the limb counter, go to RUN.
- RUN:
  - start_ready=0.
  - in_ready = !out_valid || out_ready (single output register; no bubble under full throughput).
  - On each input handshake: {c,s} = in_a + (in_b ^ {LIMB_W{sub_r}}) + carry, computed LIMB_W+1 bits wide.
  - Same handshake: out_sum<=s, carry<=c, out_valid<=1, counter++.
  - When the handshaken limb is limb NLIMBS-1: out_last<=1, out_cy<=c, go to DRAIN.
- DRAIN:
  - in_ready=0, start_ready=0.
  - When out_valid && out_ready with out_last: out_valid<=0, out_last<=0, done<=1 for one cycle, go to IDLE.
- Output register holds its value unchanged while out_valid && !out_ready.
- out_valid clears on an output handshake that has no simultaneous input handshake.
- Latency: input handshake in cycle t gives out_valid in cycle t+1. Peak throughput is 1 limb/cycle.
- Inputs ignored:
  - start_valid while busy is ignored (not queued).
  - in_valid in IDLE or DRAIN is ignored.
- Back-to-back: a new start is accepted the cycle after done is pulsed. carry is re-initialised from the new op_sub.
- NLIMBS=1: the first limb is last; RUN goes to DRAIN after one beat.
- The counter width is clog2(NLIMBS) bits, with a minimum of 1. It never wraps within an operation.
- rst asserted mid-operation: the next cycle has all reset values. In-flight limbs and carry are discarded and no done pulse is emitted.
- out_cy is 0 whenever out_last=0.

Test Plan:
1. LIMB_W=8, NLIMBS=4, add, limbs a={FF,FF,FF,FF}, b={01,00,00,00} (LS first) -> out_sum 00,00,00,00; out_last on beat 4; out_cy=1; done pulse one cycle after the last handshake.
2. Sub, a={00,00,00,00}, b={01,00,00,00} -> out_sum FF,FF,FF,FF; out_cy=0 (borrow). Sub a={05,00,00,00}, b={03,00,00,00} -> 02,00,00,00; out_cy=1.
3. Backpressure: out_ready low for 3 cycles after beat 2 -> in_ready low, out_sum/out_valid stable, no limb lost or duplicated; full throughput resumes afterwards.
4. start_valid held high during RUN/DRAIN -> start_ready=0, no restart. Next op started the cycle after done with opposite op_sub -> correct carry initialisation.
5. rst pulsed after limb 2 accepted -> next cycle busy=0, out_valid=0, start_ready=1, no done. A subsequent full add computes correctly.
6. NLIMBS=1, LIMB_W=8, add FF+FF -> single beat out_sum=FE, out_last=1, out_cy=1.
